// File: rtl/xgate_jtag_dbg_dr.sv
// xgate_jtag_dbg_dr - data-register stage of the XGATE JTAG TAP.
// It decodes the IR into the BYPASS, IDCODE and DBG_ACCESS data registers
// and muxes TDO between the IR shift path and the selected DR.
// An Update-DR of DBG_ACCESS issues one 16-bit read or write on the core
// debug bus through a req/ack handshake.
// Optional feature macro: XGATE_JTAG_TIMEOUT_EN. When it is defined, a
// request with no dbg_ack for TIMEOUT_CYC cycles is abandoned and the
// timeout status bit is set.
module xgate_jtag_dbg_dr #(
    parameter int                 IR_BITS    = 4,
    parameter logic [IR_BITS-1:0] IR_IDCODE  = 4'h1,
    parameter logic [IR_BITS-1:0] IR_DBG     = 4'h8,
    parameter logic [31:0]        IDCODE_VAL = 32'h1000_0A5F
`ifdef XGATE_JTAG_TIMEOUT_EN
    ,
    parameter int                 TIMEOUT_CYC = 255
`endif
) (
    input  logic               jtag_clk,
    input  logic               jtag_reset,
    input  logic [IR_BITS-1:0] ir_reg,
    input  logic               ir_so,
    input  logic               test_logic_rst,
    input  logic               shift_ir,
    input  logic               capture_dr,
    input  logic               shift_dr,
    input  logic               update_dr,
    input  logic               jtag_tdi,
    output logic               jtag_tdo,
    output logic               jtag_tdo_en,
    output logic               dbg_req,
    output logic               dbg_we,
    output logic [15:0]        dbg_addr,
    output logic [15:0]        dbg_wdata,
    input  logic               dbg_ack,
    input  logic [15:0]        dbg_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        bypass_q, bypass_d;
    logic [31:0] idcode_q, idcode_d;
    logic [32:0] dbgDr_q, dbgDr_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        overrun_q, overrun_d;
    logic        timeoutBit;
    logic        selIdcode;
    logic        selDbg;
    logic        busy;
    logic        drBit;

`ifdef XGATE_JTAG_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0] tmoCnt_q, tmoCnt_d;
    logic             timeout_q, timeout_d;
    assign timeoutBit = timeout_q;
`else
    assign timeoutBit = 1'b0;
`endif

    assign selIdcode = (ir_reg == IR_IDCODE);
    assign selDbg    = (ir_reg == IR_DBG);
    assign busy      = (state_q != IDLE);

    assign dbg_req   = (state_q == REQ);
    assign dbg_we    = we_q;
    assign dbg_addr  = addr_q;
    assign dbg_wdata = wdata_q;

    // Pick bit 0 of whichever DR the current instruction selects
    always_comb begin
        drBit = bypass_q;
        if (selIdcode) begin
            drBit = idcode_q[0];
        end else if (selDbg) begin
            drBit = dbgDr_q[0];
        end
    end

    assign jtag_tdo    = shift_ir ? ir_so : (shift_dr ? drBit : 1'b1);
    assign jtag_tdo_en = shift_ir | shift_dr;

    // Next-state logic for the DR shift registers, the debug FSM and the status flags
    always_comb begin
        bypass_d  = bypass_q;
        idcode_d  = idcode_q;
        dbgDr_d   = dbgDr_q;
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        overrun_d = overrun_q;
`ifdef XGATE_JTAG_TIMEOUT_EN
        timeout_d = timeout_q;
        tmoCnt_d  = '0;
`endif

        if (test_logic_rst) begin
            bypass_d = 1'b0;
            idcode_d = '0;
            dbgDr_d  = '0;
        end else if (capture_dr) begin
            if (selIdcode) begin
                idcode_d = IDCODE_VAL;
            end else if (selDbg) begin
                dbgDr_d = {rdata_q, 14'd0, timeoutBit, overrun_q, busy};
            end else begin
                bypass_d = 1'b0;
            end
        end else if (shift_dr) begin
            if (selIdcode) begin
                idcode_d = {jtag_tdi, idcode_q[31:1]};
            end else if (selDbg) begin
                dbgDr_d = {jtag_tdi, dbgDr_q[32:1]};
            end else begin
                bypass_d = jtag_tdi;
            end
        end

        if (capture_dr && selDbg) begin
            overrun_d = 1'b0;
`ifdef XGATE_JTAG_TIMEOUT_EN
            timeout_d = 1'b0;
`endif
        end

        if (update_dr && selDbg && busy) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (update_dr && selDbg) begin
                    we_d    = dbgDr_q[0];
                    addr_d  = dbgDr_q[16:1];
                    wdata_d = dbgDr_q[32:17];
                    state_d = REQ;
                end
            end
            REQ: begin
                if (dbg_ack) begin
                    if (!we_q) begin
                        rdata_d = dbg_rdata;
                    end
                    state_d = DONE;
                end
`ifdef XGATE_JTAG_TIMEOUT_EN
                else if (tmoCnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmoCnt_d = tmoCnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (test_logic_rst) begin
            state_d = IDLE;
`ifdef XGATE_JTAG_TIMEOUT_EN
            tmoCnt_d = '0;
`endif
        end
    end

    // State register with synchronous reset
    always_ff @(posedge jtag_clk) begin
        if (jtag_reset) begin
            state_q   <= IDLE;
            bypass_q  <= 1'b0;
            idcode_q  <= '0;
            dbgDr_q   <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            overrun_q <= 1'b0;
`ifdef XGATE_JTAG_TIMEOUT_EN
            timeout_q <= 1'b0;
            tmoCnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            bypass_q  <= bypass_d;
            idcode_q  <= idcode_d;
            dbgDr_q   <= dbgDr_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            overrun_q <= overrun_d;
`ifdef XGATE_JTAG_TIMEOUT_EN
            timeout_q <= timeout_d;
            tmoCnt_q  <= tmoCnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_xgate_jtag_dbg_dr.sv
// tb_xgate_jtag_dbg_dr - directed bench for the XGATE JTAG DR stage.
// A vector table covers IDCODE/BYPASS/DBG scans; hand-written sequences
// cover the debug-bus handshake, overrun, abort and timeout cases.
module tb_xgate_jtag_dbg_dr;

    logic        jtag_clk;
    logic        jtag_reset;
    logic [3:0]  ir_reg;
    logic        ir_so;
    logic        test_logic_rst;
    logic        shift_ir;
    logic        capture_dr;
    logic        shift_dr;
    logic        update_dr;
    logic        jtag_tdi;
    logic        jtag_tdo;
    logic        jtag_tdo_en;
    logic        dbg_req;
    logic        dbg_we;
    logic [15:0] dbg_addr;
    logic [15:0] dbg_wdata;
    logic        dbg_ack;
    logic [15:0] dbg_rdata;

    int totalCount;
    int badCount;

    typedef struct {
        logic [3:0]  ir;
        logic [32:0] din;
        int          len;
        logic [32:0] expOut;
    } vec_t;

    vec_t vecs[7];

    xgate_jtag_dbg_dr dut (
        .jtag_clk       (jtag_clk),
        .jtag_reset     (jtag_reset),
        .ir_reg         (ir_reg),
        .ir_so          (ir_so),
        .test_logic_rst (test_logic_rst),
        .shift_ir       (shift_ir),
        .capture_dr     (capture_dr),
        .shift_dr       (shift_dr),
        .update_dr      (update_dr),
        .jtag_tdi       (jtag_tdi),
        .jtag_tdo       (jtag_tdo),
        .jtag_tdo_en    (jtag_tdo_en),
        .dbg_req        (dbg_req),
        .dbg_we         (dbg_we),
        .dbg_addr       (dbg_addr),
        .dbg_wdata      (dbg_wdata),
        .dbg_ack        (dbg_ack),
        .dbg_rdata      (dbg_rdata)
    );

    // Free-running 10 ns test clock
    initial begin
        jtag_clk = 1'b0;
        forever #5 jtag_clk = ~jtag_clk;
    end

    // Hard stop in case a sequence wedges
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [32:0] act, input logic [32:0] exp);
        totalCount++;
        if (act !== exp) begin
            badCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge jtag_clk);
    endtask

    // One Capture-DR, len Shift-DR cycles, then an idle (Exit1) cycle
    task automatic drScan(input logic [3:0] ir, input logic [32:0] din, input int len,
                          output logic [32:0] dout);
        logic enOk;
        dout = '0;
        enOk = 1'b1;
        tick();
        ir_reg     = ir;
        capture_dr = 1'b1;
        for (int i = 0; i < len; i++) begin
            tick();
            capture_dr = 1'b0;
            shift_dr   = 1'b1;
            jtag_tdi   = din[i];
            #1;
            dout[i] = jtag_tdo;
            if (jtag_tdo_en !== 1'b1) enOk = 1'b0;
        end
        tick();
        capture_dr = 1'b0;
        shift_dr   = 1'b0;
        jtag_tdi   = 1'b0;
        #1;
        checkOutput("tdoEnShift", {32'd0, enOk}, 33'd1);
        checkOutput("tdoIdle", {31'd0, jtag_tdo_en, jtag_tdo}, 33'b01);
    endtask

    task automatic doUpdate();
        tick();
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
        #1;
    endtask

    task automatic applyStimulus(input int idx);
        logic [32:0] dout;
        drScan(vecs[idx].ir, vecs[idx].din, vecs[idx].len, dout);
        checkOutput($sformatf("vec%0d", idx), dout, vecs[idx].expOut);
    endtask

    initial begin
        logic [32:0] d;
        int cnt;
        totalCount     = 0;
        badCount       = 0;
        jtag_reset     = 1'b1;
        ir_reg         = 4'h0;
        ir_so          = 1'b0;
        test_logic_rst = 1'b0;
        shift_ir       = 1'b0;
        capture_dr     = 1'b0;
        shift_dr       = 1'b0;
        update_dr      = 1'b0;
        jtag_tdi       = 1'b0;
        dbg_ack        = 1'b0;
        dbg_rdata      = 16'h0;

        vecs[0] = '{ir: 4'h1, din: 33'h0,          len: 32, expOut: 33'h0_1000_0A5F};
        vecs[1] = '{ir: 4'h5, din: 33'b1101,       len: 4,  expOut: 33'b1010};
        vecs[2] = '{ir: 4'hF, din: 33'b011,        len: 3,  expOut: 33'b110};
        vecs[3] = '{ir: 4'h8, din: 33'h1_FFFF_FFFF, len: 33, expOut: 33'h0};
        vecs[4] = '{ir: 4'h1, din: 33'h0_FFFF_FFFF, len: 32, expOut: 33'h0_1000_0A5F};
        vecs[5] = '{ir: 4'h0, din: 33'h1,          len: 1,  expOut: 33'h0};
        vecs[6] = '{ir: 4'h5, din: 33'hA5,         len: 8,  expOut: 33'h4A};

        repeat (3) tick();
        #1;
        checkOutput("rstReqWe", {31'd0, dbg_req, dbg_we}, 33'd0);
        checkOutput("rstAddr", {17'd0, dbg_addr}, 33'd0);
        checkOutput("rstWdata", {17'd0, dbg_wdata}, 33'd0);
        checkOutput("rstTdo", {31'd0, jtag_tdo_en, jtag_tdo}, 33'b01);
        tick();
        jtag_reset = 1'b0;

        tick();
        shift_ir = 1'b1;
        ir_so    = 1'b0;
        #1;
        checkOutput("irShift0", {31'd0, jtag_tdo_en, jtag_tdo}, 33'b10);
        ir_so = 1'b1;
        #1;
        checkOutput("irShift1", {31'd0, jtag_tdo_en, jtag_tdo}, 33'b11);
        tick();
        shift_ir = 1'b0;
        ir_so    = 1'b0;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(i);
        end

        doUpdate();
        tick();
        #1;
        checkOutput("nonDbgUpdate", {32'd0, dbg_req}, 33'd0);

        drScan(4'h8, {16'hBEEF, 16'h0040, 1'b1}, 33, d);
        checkOutput("dbgCapIdle", d, 33'h0);
        doUpdate();
        checkOutput("wrReqWe", {31'd0, dbg_req, dbg_we}, 33'b11);
        checkOutput("wrAddr", {17'd0, dbg_addr}, {17'd0, 16'h0040});
        checkOutput("wrWdata", {17'd0, dbg_wdata}, {17'd0, 16'hBEEF});
        tick();
        #1;
        checkOutput("wrReqHold", {32'd0, dbg_req}, 33'd1);
        tick();
        dbg_ack   = 1'b1;
        dbg_rdata = 16'hDEAD;
        tick();
        dbg_ack   = 1'b0;
        dbg_rdata = 16'h0;
        #1;
        checkOutput("wrReqDrop", {32'd0, dbg_req}, 33'd0);

        drScan(4'h8, {16'h0000, 16'h0042, 1'b0}, 33, d);
        checkOutput("wrKeepsRdata", d, 33'h0);
        doUpdate();
        checkOutput("rdReqWe", {31'd0, dbg_req, dbg_we}, 33'b10);
        checkOutput("rdAddr", {17'd0, dbg_addr}, {17'd0, 16'h0042});
        dbg_ack   = 1'b1;
        dbg_rdata = 16'h1234;
        tick();
        dbg_ack   = 1'b0;
        dbg_rdata = 16'h0;
        #1;
        checkOutput("rdReqDrop", {32'd0, dbg_req}, 33'd0);
        drScan(4'h8, 33'h0, 33, d);
        checkOutput("rdData", d, 33'h0_2468_0000);

        drScan(4'h8, {16'hAAAA, 16'h0010, 1'b1}, 33, d);
        checkOutput("ovCapIdle", d, 33'h0_2468_0000);
        doUpdate();
        checkOutput("ovReq", {32'd0, dbg_req}, 33'd1);
        drScan(4'h8, {16'h5555, 16'h0077, 1'b1}, 33, d);
        checkOutput("ovCapBusy", d, 33'h0_2468_0001);
        doUpdate();
        checkOutput("ovReqStill", {32'd0, dbg_req}, 33'd1);
        checkOutput("ovAddrKept", {17'd0, dbg_addr}, {17'd0, 16'h0010});
        checkOutput("ovWdataKept", {17'd0, dbg_wdata}, {17'd0, 16'hAAAA});
        drScan(4'h8, 33'h0, 33, d);
        checkOutput("ovFlagSet", d, 33'h0_2468_0003);
        drScan(4'h8, 33'h0, 33, d);
        checkOutput("ovFlagClr", d, 33'h0_2468_0001);
        tick();
        dbg_ack = 1'b1;
        tick();
        dbg_ack = 1'b0;
        #1;
        checkOutput("ovReqDrop", {32'd0, dbg_req}, 33'd0);

        drScan(4'h8, {16'h1111, 16'h0020, 1'b1}, 33, d);
        checkOutput("sameCapIdle", d, 33'h0_2468_0000);
        doUpdate();
        checkOutput("sameReq", {32'd0, dbg_req}, 33'd1);
        drScan(4'h8, {16'h2222, 16'h0021, 1'b0}, 33, d);
        checkOutput("sameCapBusy", d, 33'h0_2468_0001);
        tick();
        update_dr = 1'b1;
        dbg_ack   = 1'b1;
        tick();
        update_dr = 1'b0;
        dbg_ack   = 1'b0;
        #1;
        checkOutput("sameReqDrop", {32'd0, dbg_req}, 33'd0);
        checkOutput("sameAddrKept", {17'd0, dbg_addr}, {17'd0, 16'h0020});
        drScan(4'h8, 33'h0, 33, d);
        checkOutput("sameOverrun", d, 33'h0_2468_0002);

        tick();
        dbg_ack   = 1'b1;
        dbg_rdata = 16'hFFFF;
        tick();
        dbg_ack   = 1'b0;
        dbg_rdata = 16'h0;
        #1;
        checkOutput("idleAckReq", {32'd0, dbg_req}, 33'd0);
        drScan(4'h8, 33'h0, 33, d);
        checkOutput("idleAckIgnored", d, 33'h0_2468_0000);

        drScan(4'h8, {16'h0000, 16'h0033, 1'b0}, 33, d);
        checkOutput("longCapIdle", d, 33'h0_2468_0000);
        doUpdate();
        checkOutput("longReq", {32'd0, dbg_req}, 33'd1);
`ifdef XGATE_JTAG_TIMEOUT_EN
        cnt = 1;
        while (dbg_req === 1'b1 && cnt < 400) begin
            tick();
            #1;
            if (dbg_req === 1'b1) cnt++;
        end
        checkOutput("timeoutCycles", 33'(cnt), 33'd255);
        drScan(4'h8, 33'h0, 33, d);
        checkOutput("timeoutFlag", d, 33'h0_2468_0004);
        drScan(4'h8, {16'h0000, 16'h0033, 1'b0}, 33, d);
        checkOutput("timeoutFlagClr", d, 33'h0_2468_0000);
        doUpdate();
        checkOutput("abortReq", {32'd0, dbg_req}, 33'd1);
`else
        cnt = 0;
        repeat (300) begin
            tick();
            #1;
            if (dbg_req === 1'b1) cnt++;
        end
        checkOutput("noTimeoutHold", 33'(cnt), 33'd300);
        checkOutput("noTimeoutAddr", {17'd0, dbg_addr}, {17'd0, 16'h0033});
`endif
        tick();
        test_logic_rst = 1'b1;
        tick();
        test_logic_rst = 1'b0;
        #1;
        checkOutput("tlrReqDrop", {32'd0, dbg_req}, 33'd0);
        tick();
        #1;
        checkOutput("tlrReqStays", {32'd0, dbg_req}, 33'd0);
        drScan(4'h8, 33'h0, 33, d);
        checkOutput("tlrKeepsRdata", d, 33'h0_2468_0000);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
